mem_io_responder: RTL and testbench
===================================

MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

Interface
REQ-001 The block SHALL have parameter ADDR_BITS, default 10, meaning RAM depth of 2^ADDR_BITS 16-bit words.
REQ-002 The block SHALL have parameter IO_ADDR, default 16'hFFFF, meaning the address decoded as the datapath I/O port.
REQ-003 The block SHALL have parameter WAIT_CYCLES, default 2, meaning the number of wait-state cycles per access, used only under MEM_WAIT_STATES_EN.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 The block SHALL have port CLK, input, 1 bit: rising-edge clock.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-007 The block SHALL have port req_valid, input, 1 bit: initiator presents a request.
REQ-008 The block SHALL have port req_ready, output, 1 bit: responder accepts the request this cycle.
REQ-009 The block SHALL have port req_we, input, 1 bit: 1 = write, 0 = read.
REQ-010 The block SHALL have port req_addr, input, 16 bits: word address.
REQ-011 The block SHALL have port req_wdata, input, 16 bits: write data.
REQ-012 The block SHALL have port rsp_valid, output, 1 bit: response available.
REQ-013 The block SHALL have port rsp_ready, input, 1 bit: initiator consumes the response.
REQ-014 The block SHALL have port rsp_rdata, output, 16 bits: read data, or echoed write data.
REQ-015 The block SHALL have port dp_input, input, 16 bits: external datapath input, returned on reads of IO_ADDR.
REQ-016 The block SHALL have port dp_out, output, 16 bits: external datapath output register, loaded by writes to IO_ADDR.

Function
REQ-017 The FSM SHALL have states IDLE, WAIT, ACCESS and RESP.
REQ-018 In IDLE, req_ready SHALL be 1; in every other state it SHALL be 0.
REQ-019 In IDLE with req_valid=1, the block SHALL capture req_we, req_addr and req_wdata, then go to ACCESS, or to WAIT when the macro is defined and WAIT_CYCLES>0.
REQ-020 WAIT SHALL last exactly WAIT_CYCLES cycles, counted by a down-counter loaded on accept, and then go to ACCESS.
REQ-021 In ACCESS, a write to IO_ADDR SHALL load dp_out.
REQ-022 In ACCESS, any other write SHALL store into RAM[addr[ADDR_BITS-1:0]]; upper address bits SHALL be ignored, so addresses wrap.
REQ-023 In ACCESS, a read of IO_ADDR SHALL sample dp_input in that cycle; any other read SHALL read RAM.
REQ-024 ACCESS SHALL always go to RESP.
REQ-025 In RESP, rsp_valid SHALL be 1 and rsp_rdata SHALL hold stable until rsp_ready=1, then the FSM SHALL go to IDLE.
REQ-026 For writes, rsp_rdata SHALL equal the written data.
REQ-027 Latency without wait states SHALL be: request accepted at edge N, rsp_valid high from edge N+2.
REQ-028 Latency with wait states SHALL be: rsp_valid high from edge N+2+WAIT_CYCLES.
REQ-029 The earliest next accept after a response SHALL be one cycle after the rsp_ready handshake; there SHALL be no back-to-back pipelining.
REQ-030 req_* changes while req_ready=0 SHALL be ignored.
REQ-031 rsp_ready asserted while rsp_valid=0 SHALL have no effect.

Reset
REQ-032 Reset SHALL force IDLE, rsp_valid=0, rsp_rdata=16'h0000, dp_out=16'h0000, and the wait counter to 0.
REQ-033 Reset SHALL dominate every other event: a write in WAIT or ACCESS coincident with reset SHALL NOT be committed.
REQ-034 RAM contents SHALL NOT be cleared by reset.

Configuration
REQ-035 With MEM_WAIT_STATES_EN defined, the WAIT state and the counter SHALL exist and honour WAIT_CYCLES; WAIT_CYCLES=0 SHALL skip WAIT.
REQ-036 Without MEM_WAIT_STATES_EN, the WAIT state and counter SHALL be absent, WAIT_CYCLES SHALL be ignored, and latency SHALL be fixed at 2.

Structure
REQ-037 The package mem_resp_pkg SHALL hold the state typedef, the default IO_ADDR, and the data width constant (16).
REQ-038 The RAM SHALL be a sub-module word_ram with a synchronous write port and a single read port, instantiated once.

Verification
REQ-039 Write 16'h1234 to address 5, rsp_ready=1 -> rsp_valid at N+2, rsp_rdata=16'h1234; a later read of address 5 returns 16'h1234.
REQ-040 Write 16'hBEEF to IO_ADDR -> dp_out=16'hBEEF after ACCESS; with dp_input=16'h00A5, a read of IO_ADDR returns 16'h00A5.
REQ-041 Write 16'h7777 to 16'h0405 (ADDR_BITS=10) -> a read of 16'h0005 returns 16'h7777.
REQ-042 Hold rsp_ready=0 for 5 cycles during a read -> rsp_valid and rsp_rdata stay stable, req_ready stays 0, and a new req_valid is not accepted.
REQ-043 Assert reset during WAIT of a write with the macro defined and WAIT_CYCLES=2 -> IDLE next cycle, the RAM word is unchanged, and dp_out=0.
REQ-044 With MEM_WAIT_STATES_EN defined and WAIT_CYCLES=3, issue a read -> rsp_valid rises exactly at N+5.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared state type, data width and default I/O address for mem_io_responder.
package mem_resp_pkg;
  localparam int DATA_W = 16;
  localparam logic [DATA_W-1:0] IO_ADDR_DEF = 16'hFFFF;
  typedef enum logic [1:0] {
    IDLE,
`ifdef MEM_WAIT_STATES_EN
    WAIT,
`endif
    ACCESS,
    RESP
  } state_t;
endpackage

// File: rtl/word_ram.sv
// word_ram: single-port word RAM with a synchronous write and an asynchronous read (clk, we, addr, wdata -> rdata).
module word_ram #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) if (we) mem[addr] <= wdata;
  assign rdata = mem[addr];
endmodule

// File: rtl/mem_io_responder.sv
// mem_io_responder: valid/ready memory responder with a word RAM and one datapath I/O port (CLK, reset, req_*, rsp_*, dp_input, dp_out); MEM_WAIT_STATES_EN adds WAIT_CYCLES wait states.
module mem_io_responder
  import mem_resp_pkg::*;
#(
  parameter int                ADDR_BITS   = 10,
  parameter logic [DATA_W-1:0] IO_ADDR     = IO_ADDR_DEF,
  parameter int                WAIT_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [15:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic [DATA_W-1:0] dp_input,
  output logic [DATA_W-1:0] dp_out
);
  state_t state, state_d, accept_next;
  logic we_q;
  logic [15:0] addr_q;
  logic [DATA_W-1:0] wdata_q, ram_rdata;
  logic is_io, ram_we, cnt_done;
  assign req_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  assign is_io = addr_q == IO_ADDR;
  // reset gates the RAM write so an in-flight write is never committed
  assign ram_we = state == ACCESS && we_q && !is_io && !reset;
`ifdef MEM_WAIT_STATES_EN
  localparam int CW = WAIT_CYCLES > 0 ? $clog2(WAIT_CYCLES + 1) : 1;
  logic [CW-1:0] cnt;
  assign accept_next = WAIT_CYCLES > 0 ? WAIT : ACCESS;
  // loaded with WAIT_CYCLES on accept; WAIT is left during the cycle that holds 1
  assign cnt_done = cnt <= CW'(1);
  always_ff @(posedge CLK)
    if (reset) cnt <= '0;
    else if (state == IDLE && req_valid) cnt <= CW'(WAIT_CYCLES);
    else if (state == WAIT) cnt <= cnt - 1'b1;
`else
  logic unused_wait;
  assign unused_wait = |WAIT_CYCLES;
  assign accept_next = ACCESS;
  assign cnt_done = 1'b1;
`endif
  word_ram #(.AW(ADDR_BITS), .DW(DATA_W)) u_ram (
    .clk(CLK),
    .we(ram_we),
    .addr(addr_q[ADDR_BITS-1:0]),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );
  always_comb begin
    state_d = state;
    case (state)
      IDLE:   state_d = req_valid ? accept_next : IDLE;
`ifdef MEM_WAIT_STATES_EN
      WAIT:   state_d = cnt_done ? ACCESS : WAIT;
`endif
      ACCESS: state_d = RESP;
      RESP:   state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (reset) begin
      state <= IDLE;
      rsp_rdata <= '0;
      dp_out <= '0;
    end else begin
      state <= state_d;
      if (state == ACCESS) rsp_rdata <= we_q ? wdata_q : is_io ? dp_input : ram_rdata;
      if (state == ACCESS && we_q && is_io) dp_out <= wdata_q;
    end
  end
  always_ff @(posedge CLK)
    if (req_ready && req_valid) {we_q, addr_q, wdata_q} <= {req_we, req_addr, req_wdata};
endmodule

// File: tb/tb_mem_io_responder.sv
// tb_mem_io_responder: randomized self-checking bench for mem_io_responder against a RAM/dp_out model.
module tb_mem_io_responder;
  localparam int WC = 3;
  localparam logic [15:0] IOA = 16'hFFFF;
`ifdef MEM_WAIT_STATES_EN
  localparam int LAT = 2 + WC;
`else
  localparam int LAT = 2;
`endif
  logic CLK = 0, reset = 1, req_valid = 0, req_we = 0, rsp_ready = 0;
  logic req_ready, rsp_valid;
  logic [15:0] req_addr = 0, req_wdata = 0, dp_input = 0, rsp_rdata, dp_out;
  int checks = 0, errors = 0;
  logic [15:0] mem_m [1024];
  bit known [1024];
  logic [15:0] dp_m = 0;

  always #5 CLK = ~CLK;

  mem_io_responder #(.ADDR_BITS(10), .IO_ADDR(IOA), .WAIT_CYCLES(WC)) dut (
    .CLK(CLK), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .dp_input(dp_input), .dp_out(dp_out)
  );

  task automatic xact(input logic we, input logic [15:0] a, input logic [15:0] d, input int hold);
    logic [15:0] exp;
    int k;
    exp = we ? d : (a == IOA ? dp_input : mem_m[a[9:0]]);
    req_valid = 1; req_we = we; req_addr = a; req_wdata = d; rsp_ready = (hold == 0);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL idle_ready got %b want 1", req_ready); end
    @(posedge CLK); @(negedge CLK);
    k = 1;
    while (rsp_valid !== 1'b1 && k < 40) begin
      checks++;
      if (req_ready !== 1'b0) begin errors++; $display("FAIL busy_ready got %b want 0", req_ready); end
      req_valid = 1'($urandom); req_we = 1'($urandom); req_addr = 16'($urandom); req_wdata = 16'($urandom);
      @(negedge CLK);
      k++;
    end
    checks++;
    if (k != LAT) begin errors++; $display("FAIL latency addr %h got %0d want %0d", a, k, LAT); end
    checks++;
    if (rsp_rdata !== exp) begin errors++; $display("FAIL rdata addr %h we %b got %h want %h", a, we, rsp_rdata, exp); end
    if (we) begin
      if (a == IOA) dp_m = d;
      else begin mem_m[a[9:0]] = d; known[a[9:0]] = 1; end
    end
    checks++;
    if (dp_out !== dp_m) begin errors++; $display("FAIL dp_out got %h want %h", dp_out, dp_m); end
    for (int i = 0; i < hold; i++) begin
      req_valid = 1; req_we = 1'($urandom); req_addr = 16'($urandom); req_wdata = 16'($urandom);
      @(negedge CLK);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== exp || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold valid/ready/rdata got %b/%b/%h want 1/0/%h", rsp_valid, req_ready, rsp_rdata, exp);
      end
    end
    req_valid = 0; rsp_ready = 1;
    @(posedge CLK); @(negedge CLK);
    rsp_ready = 0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL after_handshake valid/ready got %b/%b want 0/1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    reset = 0;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 16'h0 || dp_out !== 16'h0) begin
      errors++;
      $display("FAIL reset ready/valid/rdata/dp got %b/%b/%h/%h want 1/0/0000/0000", req_ready, rsp_valid, rsp_rdata, dp_out);
    end
  endtask

  task automatic test_write_read;
    xact(1, 16'd5, 16'h1234, 0);
    xact(0, 16'd5, 16'h0, 0);
  endtask

  task automatic test_io;
    xact(1, IOA, 16'hBEEF, 0);
    dp_input = 16'h00A5;
    xact(0, IOA, 16'h0, 0);
  endtask

  task automatic test_wrap;
    xact(1, 16'h0405, 16'h7777, 0);
    xact(0, 16'h0005, 16'h0, 0);
  endtask

  task automatic test_backpressure;
    xact(0, 16'h0005, 16'h0, 5);
  endtask

  task automatic test_reset_mid;
    logic [15:0] targets [2];
    targets[0] = 16'h0005;
    targets[1] = IOA;
    foreach (targets[t]) begin
      req_valid = 1; req_we = 1; req_addr = targets[t]; req_wdata = 16'hDEAD; rsp_ready = 1;
      @(posedge CLK); @(negedge CLK);
      req_valid = 0; reset = 1;
      @(posedge CLK); @(negedge CLK);
      reset = 0; rsp_ready = 0; dp_m = 0;
      checks++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || dp_out !== 16'h0 || rsp_rdata !== 16'h0) begin
        errors++;
        $display("FAIL reset_mid ready/valid/dp/rdata got %b/%b/%h/%h want 1/0/0000/0000", req_ready, rsp_valid, dp_out, rsp_rdata);
      end
      xact(0, 16'h0005, 16'h0, 0);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 40; i++) begin
      logic [15:0] a;
      logic we;
      dp_input = 16'($urandom);
      a = ($urandom_range(0, 7) == 0) ? IOA : {6'($urandom), 10'($urandom_range(0, 15))};
      we = 1'($urandom);
      if (!we && a != IOA && !known[a[9:0]]) we = 1;
      xact(we, a, 16'($urandom), $urandom_range(0, 3));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_write_read;
    test_io;
    test_wrap;
    test_backpressure;
    test_reset_mid;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
